// File: rtl/riscv_conv_engine.sv
// 3x3 convolution engine: nine programmable weights, TILE x TILE pixel load,
// OUT x OUT saturated/relu'd results on a valid/ready stream.
// Ports: clk, rst_n (sync, active-low); command enable_i/operator_i/operand_i1/operand_i2 with ready_o;
// pixel data_i/data_valid_i/data_ready_o; result_o/result_valid_o/result_ready_i; done_o pulse.
// Optional: define RISCV_CONV_MAXPOOL_EN to emit only the maximum of all outputs.
package riscv_conv_pkg;
  localparam int MAC_OP_WIDTH = 4;
  localparam logic [MAC_OP_WIDTH-1:0] W_WB_OP = 4'd1;
  localparam logic [MAC_OP_WIDTH-1:0] CON_OP  = 4'd2;
  localparam logic [MAC_OP_WIDTH-1:0] RELU_OP = 4'd3;
endpackage

module riscv_conv_engine
  import riscv_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int TILE   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [MAC_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_i1,
  input  logic [31:0]             operand_i2,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [31:0]             result_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic                    ready_o,
  output logic                    done_o
);
  localparam int OUT  = TILE - 2;
  localparam int NPIX = TILE * TILE;
  localparam int PW   = $clog2(NPIX);
  localparam int CW   = (OUT > 1) ? $clog2(OUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_CALC, ST_OUT, ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] w_q   [9];
  logic signed [DATA_W-1:0] buf_q [NPIX];
  logic [PW-1:0] pix_cnt_q;
  logic [CW-1:0] r_q, c_q;
  logic relu_q, relu_def_q;
  logic signed [ACC_W-1:0] res_q, acc;
  logic [PW-1:0] pidx;
  logic [3:0] widx;
  logic cmd_wb, cmd_con, cmd_relu, wb_hit;
  logic pix_fire, last_pix, res_fire;
  logic last_pos, adv;
  logic unused;

  assign unused = ^operand_i2[31:DATA_W];

  function automatic logic signed [31:0] sat32(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [63:0] x;
    x = 64'(v);
    if (x > 64'sh7fff_ffff)
      return 32'sh7fff_ffff;
    if (x < -64'sh8000_0000)
      return 32'sh8000_0000;
    return 32'(x);
  endfunction

  function automatic logic signed [31:0] post(
    input logic signed [ACC_W-1:0] v,
    input logic                    relu
  );
    logic signed [31:0] s;
    s = sat32(v);
    return (relu && s[31]) ? 32'sd0 : s;
  endfunction

  always_comb begin
    cmd_wb   = 1'b0;
    cmd_con  = 1'b0;
    cmd_relu = 1'b0;
    if (enable_i && state_q == ST_IDLE) begin
      unique case (1'b1)
        (operator_i == W_WB_OP): cmd_wb   = 1'b1;
        (operator_i == CON_OP):  cmd_con  = 1'b1;
        (operator_i == RELU_OP): cmd_relu = 1'b1;
        default: ;
      endcase
    end
  end

  assign wb_hit   = cmd_wb && (operand_i1 < 32'd9);
  assign pix_fire = (state_q == ST_LOAD) && data_valid_i;
  assign last_pix = (pix_cnt_q == PW'(NPIX - 1));
  assign res_fire = (state_q == ST_OUT) && result_ready_i;
  assign last_pos = (r_q == CW'(OUT - 1)) && (c_q == CW'(OUT - 1));

  always_comb begin
    acc  = '0;
    pidx = '0;
    widx = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        widx = 4'(i * 3 + j);
        pidx = PW'((int'(r_q) + i) * TILE + int'(c_q) + j);
        acc  = acc + ACC_W'(w_q[widx]) * ACC_W'(buf_q[pidx]);
      end
    end
  end

`ifdef RISCV_CONV_MAXPOOL_EN
  logic signed [31:0] cand;
  assign cand = post(acc, relu_q);
  // positions advance inside CALC; results never leave until the max is done
  assign adv  = (state_q == ST_CALC) && !last_pos;
`else
  assign adv  = res_fire && !last_pos;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_con) state_d = ST_LOAD;
      ST_LOAD: if (pix_fire && last_pix) state_d = ST_CALC;
`ifdef RISCV_CONV_MAXPOOL_EN
      ST_CALC: if (last_pos) state_d = ST_OUT;
      ST_OUT:  if (res_fire) state_d = ST_DONE;
`else
      ST_CALC: state_d = ST_OUT;
      ST_OUT:
        if (res_fire) state_d = last_pos ? ST_DONE : ST_CALC;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      r_q        <= '0;
      c_q        <= '0;
      relu_q     <= 1'b0;
      relu_def_q <= 1'b0;
      res_q      <= '0;
      for (int k = 0; k < 9; k++)
        w_q[k] <= DATA_W'(k + 1);
    end else begin
      state_q <= state_d;
      if (wb_hit)
        w_q[operand_i1[3:0]] <= operand_i2[DATA_W-1:0];
      if (cmd_relu)
        relu_def_q <= 1'b1;
      if (cmd_con) begin
        relu_q    <= operand_i1[0] | relu_def_q;
        pix_cnt_q <= '0;
        r_q       <= '0;
        c_q       <= '0;
      end
      if (pix_fire)
        pix_cnt_q <= pix_cnt_q + 1'b1;
      if (adv) begin
        if (c_q == CW'(OUT - 1)) begin
          c_q <= '0;
          r_q <= r_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
`ifdef RISCV_CONV_MAXPOOL_EN
      if (state_q == ST_CALC) begin
        if ((r_q == '0 && c_q == '0) || cand > sat32(res_q))
          res_q <= ACC_W'(cand);
      end
`else
      if (state_q == ST_CALC)
        res_q <= acc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (pix_fire)
      buf_q[pix_cnt_q] <= data_i;
  end

  assign result_o       = post(res_q, relu_q);
  assign ready_o        = (state_q == ST_IDLE);
  assign data_ready_o   = (state_q == ST_LOAD);
  assign result_valid_o = (state_q == ST_OUT);
  assign done_o         = (state_q == ST_DONE);
endmodule

// File: tb/tb_riscv_conv_engine.sv
// Scoreboard bench for riscv_conv_engine (TILE=4, DATA_W=16, ACC_W=40).
// Expected results are queued at command time and popped as results are accepted.
module tb_riscv_conv_engine;
  import riscv_conv_pkg::*;

  localparam int DW = 16;
  localparam int NP = 16;
  localparam int NO = 2;
`ifdef RISCV_CONV_MAXPOOL_EN
  localparam int NRES = 1;
`else
  localparam int NRES = NO * NO;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_i = 1'b0;
  logic [MAC_OP_WIDTH-1:0] operator_i = '0;
  logic [31:0] operand_i1 = '0;
  logic [31:0] operand_i2 = '0;
  logic [DW-1:0] data_i = '0;
  logic data_valid_i = 1'b0;
  logic data_ready_o;
  logic [31:0] result_o;
  logic result_valid_o;
  logic result_ready_i = 1'b0;
  logic ready_o;
  logic done_o;

  riscv_conv_engine #(.DATA_W(16), .ACC_W(40), .TILE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .enable_i(enable_i), .operator_i(operator_i),
    .operand_i1(operand_i1), .operand_i2(operand_i2),
    .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .result_o(result_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .ready_o(ready_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int exp_q[$];
  int wm[9];
  int px[NP];
  bit relu_def;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] req);
    n_chk++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(req), req);
    end
  endtask

  function automatic int sat_relu(longint v, bit relu);
    longint s;
    s = v;
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    if (relu && s < 0) s = 0;
    return int'(s);
  endfunction

  task automatic push_model(bit relu);
    int best;
    best = 0;
    for (int r = 0; r < NO; r++) begin
      for (int c = 0; c < NO; c++) begin
        longint s;
        int v;
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += longint'(wm[i*3+j]) * longint'(px[(r+i)*4 + c + j]);
        v = sat_relu(s, relu);
`ifdef RISCV_CONV_MAXPOOL_EN
        if ((r == 0 && c == 0) || v > best) best = v;
`else
        exp_q.push_back(v);
`endif
      end
    end
`ifdef RISCV_CONV_MAXPOOL_EN
    exp_q.push_back(best);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) wm[k] = k + 1;
    relu_def = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(logic [MAC_OP_WIDTH-1:0] op, int a, int b);
    enable_i = 1'b1;
    operator_i = op;
    operand_i1 = a;
    operand_i2 = b;
    @(negedge clk);
    enable_i = 1'b0;
    operand_i1 = '0;
  endtask

  task automatic wr_w(int idx, int val);
    pulse(W_WB_OP, idx, val);
    if (idx >= 0 && idx < 9) wm[idx] = val;
  endtask

  task automatic set_all_w(int val);
    for (int k = 0; k < 9; k++) wr_w(k, val);
  endtask

  task automatic load(int nbeats, bit gap);
    for (int b = 0; b < nbeats; b++) begin
      int t;
      if (gap && (b % 3 == 1)) begin
        data_valid_i = 1'b0;
        @(negedge clk);
      end
      data_valid_i = 1'b1;
      data_i = DW'(px[b]);
      t = 0;
      while (!data_ready_o && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("pix_ready", data_ready_o, 1'b1);
      @(negedge clk);
    end
    data_valid_i = 1'b0;
  endtask

  task automatic collect(bit stall);
    for (int n = 0; n < NRES; n++) begin
      int t;
      int e;
      t = 0;
      while (!result_valid_o && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("res_valid", result_valid_o, 1'b1);
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
        e = 0;
      end else begin
        e = exp_q.pop_front();
      end
      if (stall) begin
        check("res_pre", result_o, e);
        @(negedge clk);
        check("stall_valid", result_valid_o, 1'b1);
        check("stall_hold", result_o, e);
      end
      check("result", result_o, e);
      result_ready_i = 1'b1;
      @(negedge clk);
      result_ready_i = 1'b0;
    end
    check("done", done_o, 1'b1);
    @(negedge clk);
    check("done_pulse", done_o, 1'b0);
    check("idle", ready_o, 1'b1);
  endtask

  task automatic run(bit relu, bit model, bit gap, bit stall);
    pulse(CON_OP, {31'd0, relu}, 0);
    if (model) push_model(relu | relu_def);
    load(NP, gap);
    collect(stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_ready", ready_o, 1'b1);
    check("rst_dready", data_ready_o, 1'b0);
    check("rst_rvalid", result_valid_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_result", result_o, 32'd0);

    for (int k = 0; k < NP; k++) px[k] = 1;
    run(1'b0, 1'b1, 1'b1, 1'b0);

    set_all_w(1);
    for (int k = 0; k < NP; k++) px[k] = k + 1;
`ifdef RISCV_CONV_MAXPOOL_EN
    exp_q.push_back(99);
`else
    exp_q.push_back(54);
    exp_q.push_back(63);
    exp_q.push_back(90);
    exp_q.push_back(99);
`endif
    run(1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < NP; k++) px[k] = -1;
    run(1'b1, 1'b1, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0);

    wr_w(9, 77);
    check("bad_idx_idle", ready_o, 1'b1);
    for (int k = 0; k < NP; k++) px[k] = 1;
    run(1'b0, 1'b1, 1'b0, 1'b0);

    set_all_w(32767);
    for (int k = 0; k < NP; k++) px[k] = 32767;
    run(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NP; k++) px[k] = -32768;
    run(1'b0, 1'b1, 1'b0, 1'b0);

    set_all_w(0);
    wr_w(4, 32767);
    for (int k = 0; k < NP; k++) px[k] = 32767;
    pulse(CON_OP, 0, 0);
    push_model(relu_def);
    pulse(W_WB_OP, 4, 5);
    pulse(CON_OP, 0, 0);
    load(NP, 1'b0);
    collect(1'b1);

    pulse(RELU_OP, 0, 0);
    relu_def = 1'b1;
    for (int k = 0; k < NP; k++) px[k] = -1;
    run(1'b0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < NP; k++) px[k] = 3;
    pulse(CON_OP, 0, 0);
    load(6, 1'b0);
    data_valid_i = 1'b1;
    data_i = DW'(px[6]);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    data_valid_i = 1'b0;
    for (int k = 0; k < 9; k++) wm[k] = k + 1;
    relu_def = 1'b0;
    check("mid_rst_ready", ready_o, 1'b1);
    check("mid_rst_dready", data_ready_o, 1'b0);
    check("mid_rst_result", result_o, 32'd0);
    for (int k = 0; k < NP; k++) px[k] = -(k + 1);
    run(1'b0, 1'b1, 1'b0, 1'b0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
